// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode/state types and operand-sign helpers for the iterative multiply/divide unit
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } mdu_op_e;
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} mdu_state_e;
  function automatic logic is_div(mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction
  function automatic logic is_rem(mdu_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction
  function automatic logic a_signed(mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic b_signed(mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-division step
// rem_in/dvd_bit: partial remainder and next dividend bit; divisor: |b|
// rem_out/q: updated remainder and quotient bit
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q
);
  logic [WIDTH:0] t, d;
  assign t = {rem_in, dvd_bit};
  assign d = t - {1'b0, divisor};
  assign q = t >= {1'b0, divisor};
  assign rem_out = q ? d[WIDTH-1:0] : t[WIDTH-1:0];
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M-style multiply/divide unit, BPC result bits per cycle
// clk/reset: clock, async active-high reset
// in_valid/in_ready/in_op/in_a/in_b: request handshake and operands
// kill: abort any op in flight; out_valid/out_ready/out_result: result handshake; busy: PREP/CALC/FIX
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N);
  mdu_state_e state, nxt;
  mdu_op_e op;
  logic [WIDTH-1:0] a_r, b_r, abs_a, abs_b, spec_val, div_sel, div_res, fix_res;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [CW-1:0] cnt;
  logic neg, sa, sb, b_zero, ovf, spec;
  logic [BPC:0][2*WIDTH-1:0] mul_c;
  logic [BPC:0][WIDTH-1:0] rem_c, quo_c;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state inside {PREP, CALC, FIX};
  assign sa       = a_signed(op) & a_r[WIDTH-1];
  assign sb       = b_signed(op) & b_r[WIDTH-1];
  assign abs_a    = sa ? -a_r : a_r;
  assign abs_b    = sb ? -b_r : b_r;
  assign b_zero   = b_r == '0;
  assign ovf      = a_signed(op) & is_div(op) & (a_r == {1'b1, {(WIDTH-1){1'b0}}}) & (&b_r);
  assign spec     = is_div(op) & (b_zero | ovf);
  assign spec_val = b_zero ? (is_rem(op) ? a_r : '1) : (is_rem(op) ? '0 : a_r);
  // acc holds {hi, lo}: multiply accumulates into hi while the multiplier shifts out of lo;
  // divide keeps the remainder in hi while dividend bits leave lo and quotient bits enter it
  assign mul_c[0] = acc;
  assign rem_c[0] = acc[2*WIDTH-1:WIDTH];
  assign quo_c[0] = acc[WIDTH-1:0];
  for (genvar i = 0; i < BPC; i++) begin : g_step
    logic [WIDTH:0] s;
    logic qb;
    assign s = {1'b0, mul_c[i][2*WIDTH-1:WIDTH]} + (mul_c[i][0] ? {1'b0, a_r} : '0);
    assign mul_c[i+1] = {s, mul_c[i][WIDTH-1:1]};
    mdu_divstep #(.WIDTH(WIDTH)) u_div (
      .rem_in (rem_c[i]),
      .dvd_bit(quo_c[i][WIDTH-1]),
      .divisor(b_r),
      .rem_out(rem_c[i+1]),
      .q      (qb)
    );
    assign quo_c[i+1] = {quo_c[i][WIDTH-2:0], qb};
  end
  assign acc_nxt = is_div(op) ? {rem_c[BPC], quo_c[BPC]} : mul_c[BPC];
  assign prod    = neg ? -acc : acc;
  assign div_sel = is_rem(op) ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
  assign div_res = neg ? -div_sel : div_sel;
  assign fix_res = is_div(op) ? div_res : (op == OP_MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = in_valid ? PREP : IDLE;
      PREP:    nxt = spec ? DONE : CALC;
      CALC:    nxt = cnt == '0 ? FIX : CALC;
      FIX:     nxt = DONE;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op         <= OP_MUL;
      a_r        <= '0;
      b_r        <= '0;
      acc        <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      out_result <= '0;
    end else if (!kill) begin
      if (state == IDLE && in_valid) begin
        op  <= mdu_op_e'(in_op);
        a_r <= in_a;
        b_r <= in_b;
      end
      if (state == PREP) begin
        a_r <= abs_a;
        b_r <= abs_b;
        acc <= {{WIDTH{1'b0}}, is_div(op) ? abs_a : abs_b};
        cnt <= CW'(N - 1);
        neg <= is_rem(op) ? sa : sa ^ sb;
        if (spec) out_result <= spec_val;
      end
      if (state == CALC) begin
        acc <= acc_nxt;
        cnt <= cnt - CW'(1);
      end
      if (state == FIX) out_result <= fix_res;
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: checks mdu_iter at BPC=1,2,4 against an arithmetic reference model
module tb_mdu_iter;
  import mdu_pkg::*;
  logic clk = 1'b0, reset = 1'b0, kill = 1'b0, out_ready = 1'b0;
  logic [2:0] in_op = 3'd0;
  logic [31:0] in_a = '0, in_b = '0;
  logic in_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic in_ready [3], out_valid [3], busy [3];
  logic [31:0] out_result [3];
  int n_cmp = 0, n_bad = 0;
  bit pend [3] = '{0, 0, 0};
  int edges [3] = '{0, 0, 0}, exp_lat [3] = '{0, 0, 0};
  logic [31:0] exp_res [3];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g_dut
    mdu_iter #(.WIDTH(32), .BPC(1 << k)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid[k]), .in_ready(in_ready[k]),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .kill(kill), .out_valid(out_valid[k]),
      .out_ready(out_ready), .out_result(out_result[k]), .busy(busy[k])
    );
  end
  function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [65:0] x, y, p;
    int qs, rs;
    bit as_s, bs_s;
    as_s = op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6;
    bs_s = op == 3'd1 || op == 3'd4 || op == 3'd6;
    x = {{34{as_s & a[31]}}, a};
    y = {{34{bs_s & b[31]}}, b};
    p = x * y;
    if (!op[2]) return op == 3'd0 ? p[31:0] : p[63:32];
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      qs = $signed(a) / $signed(b);
      rs = $signed(a) % $signed(b);
      return op[1] ? rs : qs;
    end
    return op[1] ? a % b : a / b;
  endfunction
  function automatic int lat_model(logic [2:0] op, logic [31:0] a, logic [31:0] b, int d);
    bit sp;
    sp = op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return sp ? 1 : (32 >> d) + 2;
  endfunction
  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", name, d, act, exp, $time);
    end
  endtask
  task automatic chkb(string name, int d, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %b want %b at %0t", name, d, act, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge clk or posedge reset);
    for (int d = 0; d < 3; d++) begin
      if (reset || kill) pend[d] = 0;
      else if (pend[d]) begin
        if (edges[d] >= exp_lat[d]) begin
          if (out_ready) pend[d] = 0;
        end else edges[d]++;
      end else if (in_valid[d]) begin
        pend[d]    = 1;
        edges[d]   = 0;
        exp_res[d] = ref_model(in_op, in_a, in_b);
        exp_lat[d] = lat_model(in_op, in_a, in_b, d);
      end
    end
  end
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chkb("in_ready", d, in_ready[d], !pend[d]);
      chkb("out_valid", d, out_valid[d], pend[d] && edges[d] >= exp_lat[d]);
      chkb("busy", d, busy[d], pend[d] && edges[d] < exp_lat[d]);
      if (pend[d] && edges[d] >= exp_lat[d]) chk("stream_result", d, out_result[d], exp_res[d]);
    end
  end
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, r;
    bit          sp;
    int          hold;
  } vec_t;
  vec_t vecs [20] = '{
    '{OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 3},
    '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0},
    '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0},
    '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1},
    '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0},
    '{OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0},
    '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 0},
    '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, 0},
    '{OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 0},
    '{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         0, 2},
    '{OP_DIVU,   32'd100,       32'd7,         32'd14,        0, 0},
    '{OP_REMU,   32'd100,       32'd7,         32'd2,         0, 0},
    '{OP_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 0, 0},
    '{OP_REMU,   32'hFFFF_FFFF, 32'd10,        32'd5,         0, 0},
    '{OP_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1, 0},
    '{OP_REMU,   32'd100,       32'd0,         32'd100,       1, 2},
    '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0},
    '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0},
    '{OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0},
    '{OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1, 0}
  };
  task automatic run(int d, logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] r, bit sp, int hold);
    int t = 0;
    chk("model", d, ref_model(op, a, b), r);
    @(posedge clk); #1;
    in_op = op; in_a = a; in_b = b; in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0; in_a = $urandom; in_b = $urandom; in_op = 3'($urandom);
    while (!out_valid[d] && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("latency", d, t, sp ? 1 : (32 >> d) + 2);
    chk("result", d, out_result[d], r);
    repeat (hold) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chkb("released", d, out_valid[d], 1'b0);
  endtask
  task automatic kill_test(int d);
    int kc = (32 >> d) > 10 ? 10 : (32 >> d) - 2;
    @(posedge clk); #1;
    in_op = OP_DIVU; in_a = 32'd1000; in_b = 32'd3; in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    repeat (kc) @(posedge clk);
    #1 kill = 1'b1; in_valid[d] = 1'b1; in_op = OP_MUL; in_a = 32'd9; in_b = 32'd9;
    @(posedge clk); #1;
    kill = 1'b0; in_valid[d] = 1'b0;
    chkb("kill_ready", d, in_ready[d], 1'b1);
    chkb("kill_busy", d, busy[d], 1'b0);
    repeat (40) @(posedge clk);
    #1 chkb("kill_no_valid", d, out_valid[d], 1'b0);
  endtask
  task automatic reset_test(int d);
    @(posedge clk); #1;
    in_op = OP_DIV; in_a = 32'd1000; in_b = 32'd7; in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    repeat (5) @(posedge clk);
    #1 chkb("pre_reset_busy", d, busy[d], 1'b1);
    reset = 1'b1;
    #1;
    chkb("rst_valid", d, out_valid[d], 1'b0);
    chkb("rst_ready", d, in_ready[d], 1'b1);
    chkb("rst_busy", d, busy[d], 1'b0);
    chk("rst_result", d, out_result[d], 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_result", d, out_result[d], 32'd0);
      chkb("reset_ready", d, in_ready[d], 1'b1);
    end
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      foreach (vecs[i]) run(d, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].sp, vecs[i].hold);
      kill_test(d);
      run(d, OP_MUL, 32'd3, 32'd5, 32'd15, 0, 0);
      reset_test(d);
      run(d, OP_DIVU, 32'd100, 32'd7, 32'd14, 0, 0);
    end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
